// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an NDIG-digit common-anode
//             7-segment display. Drives one shared segment decoder one digit
//             at a time. Inserts an all-anodes-off gap before every digit so
//             the display does not ghost. Takes a snapshot of the digits and
//             dots once per frame so that a time update mid-frame never tears.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - asynchronous active-low reset
//             en       - scan enable; low holds the display dark and
//                        restarts the scan
//             digits   - BCD codes, digit k = digits[4k+3:4k]
//             dots     - dot request per digit, bit k = digit k
//             lzb      - leading-zero blanking enable (used every cycle)
//             din_out  - code to the segment decoder, 4'hA = blank
//             dot_en   - dot enable to the segment decoder
//             an       - active-low digit anodes, at most one low
//             frame    - one-cycle pulse when the scan wraps to digit 0
//             idx      - index of the current digit
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NDIG-1:0]       digits,
  input  logic [NDIG-1:0]         dots,
  input  logic                    lzb,
  output logic [3:0]              din_out,
  output logic                    dot_en,
  output logic [NDIG-1:0]         an,
  output logic                    frame,
  output logic [$clog2(NDIG)-1:0] idx
);

  localparam int unsigned IDX_W   = $clog2(NDIG);
  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NDIG - 1);
  localparam logic [3:0]       c_blank_code = 4'hA;

  typedef enum logic [0:0] {
    ST_BLANKING = 1'b0,
    ST_SHOWING  = 1'b1
  } state_t;

  // Scan state
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4*NDIG-1:0] snap_dig_q, snap_dig_d;
  logic [NDIG-1:0]   snap_dot_q, snap_dot_d;

  // Output registers
  logic              frame_q, frame_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [3:0]        din_q, din_d;
  logic              dot_q, dot_d;

  // Leading-zero bookkeeping, taken from the snapshot being loaded
  logic [NDIG-1:0]   dig_zero;
  logic [NDIG-1:0]   lz_blank;
  logic [3:0]        sel_dig;

  // --------------------------------------------------------------------------
  // Scan sequencing and snapshot
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    snap_dig_d = snap_dig_q;
    snap_dot_d = snap_dot_q;
    frame_d    = 1'b0;

    if (!en) begin
      state_d = ST_BLANKING;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      // The frame starts with the blanking gap of digit 0. Capture the
      // snapshot there so the whole frame shows one consistent value.
      if (state_q == ST_BLANKING && idx_q == '0 && cnt_q == '0) begin
        snap_dig_d = digits;
        snap_dot_d = dots;
      end

      unique case (state_q)
        ST_BLANKING: begin
          if (cnt_q == c_blank_last) begin
            state_d = ST_SHOWING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOWING: begin
          if (cnt_q == c_dwell_last) begin
            state_d = ST_BLANKING;
            cnt_d   = '0;
            if (idx_q == c_idx_last) begin
              idx_d   = '0;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_BLANKING;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection on the next snapshot value
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NDIG; k++) begin : g_dig_zero
      assign dig_zero[k] = (snap_dig_d[4*k +: 4] == 4'h0);
    end
  endgenerate

  // lz_blank[k] is set when digit k and every digit above it are zero.
  // Digit 0 is never blanked, so a value of all zeros still shows "0".
  always_comb begin
    lz_blank         = '0;
    lz_blank[NDIG-1] = dig_zero[NDIG-1];
    for (int k = NDIG - 2; k >= 1; k--) begin
      lz_blank[k] = dig_zero[k] & lz_blank[k+1];
    end
    lz_blank[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Output decode, computed from next-state values so that the registered
  // outputs line up with the scan state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    an_d    = '1;
    sel_dig = 4'h0;
    din_d   = 4'h0;
    dot_d   = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_dig = snap_dig_d[4*k +: 4];
        dot_d   = snap_dot_d[k];
        // The digit code is shown during blanking too, so the decoder has
        // settled before the anode turns on.
        din_d   = (lzb && lz_blank[k]) ? c_blank_code : sel_dig;
        if (state_d == ST_SHOWING) begin
          an_d[k] = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANKING;
      idx_q      <= '0;
      cnt_q      <= '0;
      snap_dig_q <= '0;
      snap_dot_q <= '0;
      frame_q    <= 1'b0;
      an_q       <= '1;
      din_q      <= 4'h0;
      dot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      snap_dig_q <= snap_dig_d;
      snap_dot_q <= snap_dot_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      din_q      <= din_d;
      dot_q      <= dot_d;
    end
  end

  assign din_out = din_q;
  assign dot_en  = dot_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign idx     = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Self-checking bench for seg7_scan_ctrl (NDIG=4, DWELL=4,
//             BLANK=2). A frame-position model predicts every output on every
//             cycle. Directed steps cover reset, leading-zero blanking,
//             snapshot tearing, enable drop and mid-frame reset. A randomized
//             section exercises mixed digit values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int DP    = BLANK + DWELL;   // digit period
  localparam int FP    = NDIG * DP;       // frame period

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic        lzb;
  logic [3:0]  din_out;
  logic        dot_en;
  logic [3:0]  an;
  logic        frame;
  logic [1:0]  idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position inside the frame plus the captured snapshot
  int          m_p;
  logic [15:0] m_dig;
  logic [3:0]  m_dot;
  logic        m_lzb;
  logic        m_frame;

  seg7_scan_ctrl #(
    .NDIG (NDIG),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .digits (digits),
    .dots   (dots),
    .lzb    (lzb),
    .din_out(din_out),
    .dot_en (dot_en),
    .an     (an),
    .frame  (frame),
    .idx    (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p     = 0;
    m_dig   = 16'h0000;
    m_dot   = 4'h0;
    m_frame = 1'b0;
    m_lzb   = lzb;
  endtask

  // Compare every output against the model's view of the current cycle
  task automatic check_all();
    int         d;
    bit         showing;
    bit         blanked;
    logic [3:0] an_e;
    logic [3:0] din_e;
    d       = m_p / DP;
    showing = (m_p % DP) >= BLANK;
    an_e    = 4'hF;
    if (showing) an_e[d] = 1'b0;
    blanked = 1'b0;
    if (m_lzb && d >= 1) begin
      blanked = 1'b1;
      for (int k = d; k < NDIG; k++)
        if (m_dig[4*k +: 4] != 4'h0) blanked = 1'b0;
    end
    din_e = blanked ? 4'hA : m_dig[4*d +: 4];
    chk("an",     32'(an),      32'(an_e));
    chk("din",    32'(din_out), 32'(din_e));
    chk("dot",    32'(dot_en),  32'(m_dot[d]));
    chk("frame",  32'(frame),   32'(m_frame));
    chk("idx",    32'(idx),     32'(d));
  endtask

  // One clock: the model consumes the inputs present at the edge
  task automatic step();
    logic        s_en;
    logic [15:0] s_dig;
    logic [3:0]  s_dot;
    logic        s_lzb;
    s_en  = en;
    s_dig = digits;
    s_dot = dots;
    s_lzb = lzb;
    @(posedge clk);
    if (!s_en) begin
      m_p     = 0;
      m_frame = 1'b0;
    end else begin
      if (m_p == 0) begin
        m_dig = s_dig;
        m_dot = s_dot;
      end
      m_frame = (m_p == FP - 1);
      m_p     = (m_p + 1) % FP;
    end
    m_lzb = s_lzb;
    #1;
    check_all();
  endtask

  // Step at least once, then until the model reaches frame position tgt
  task automatic step_to(input int tgt);
    int n;
    n = 0;
    step();
    while (m_p != tgt && n < 2 * FP) begin
      step();
      n++;
    end
    chk("step_to_bound", 32'(m_p), 32'(tgt));
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] r;
    for (int k = 0; k < NDIG; k++)
      r[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    en     = 1'b0;
    digits = 16'h0000;
    dots   = 4'h0;
    lzb    = 1'b0;
    rst_n  = 1'b1;
    model_reset();

    // Reset takes effect without any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_an",    32'(an),      32'hF);
    chk("rst_din",   32'(din_out), 32'h0);
    chk("rst_dot",   32'(dot_en),  32'h0);
    chk("rst_frame", 32'(frame),   32'h0);
    chk("rst_idx",   32'(idx),     32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Basic scan of 1234
    digits = 16'h1234;
    dots   = 4'h0;
    lzb    = 1'b0;
    en     = 1'b1;
    repeat (2 * FP) step();

    // Leading-zero blanking with 0050
    lzb    = 1'b1;
    digits = 16'h0050;
    dots   = 4'b0100;
    step_to(1);
    step_to(2);            chk("lzb_d0",  32'(din_out), 32'h0);
    step_to(2 + DP);       chk("lzb_d1",  32'(din_out), 32'h5);
    step_to(2 + 2 * DP);   chk("lzb_d2",  32'(din_out), 32'hA);
                           chk("lzb_dot", 32'(dot_en),  32'h1);
    step_to(2 + 3 * DP);   chk("lzb_d3",  32'(din_out), 32'hA);

    // All zeros: only digit 0 lit
    digits = 16'h0000;
    dots   = 4'h0;
    step_to(1);
    step_to(2);            chk("zero_d0", 32'(din_out), 32'h0);
    step_to(2 + DP);       chk("zero_d1", 32'(din_out), 32'hA);
    step_to(2 + 3 * DP);   chk("zero_d3", 32'(din_out), 32'hA);

    // Snapshot holds across a mid-frame update
    lzb    = 1'b0;
    digits = 16'h1234;
    step_to(1);
    step_to(2 + 2 * DP);
    digits = 16'h5678;
    step();                chk("tear_d2", 32'(din_out), 32'h2);
    step_to(2 + 3 * DP);   chk("tear_d3", 32'(din_out), 32'h1);
    step_to(2);            chk("new_d0",  32'(din_out), 32'h8);
    step_to(2 + DP);       chk("new_d1",  32'(din_out), 32'h7);
    step_to(2 + 2 * DP);   chk("new_d2",  32'(din_out), 32'h6);
    step_to(2 + 3 * DP);   chk("new_d3",  32'(din_out), 32'h5);

    // Enable dropped during digit 1 showing
    step_to(2 + DP);
    en = 1'b0;
    step();                chk("endrop_an",  32'(an),  32'hF);
                           chk("endrop_idx", 32'(idx), 32'h0);
    step();
    en = 1'b1;
    step();                chk("enup_blank", 32'(an), 32'hF);
    repeat (DWELL) begin
      step();              chk("enup_show",  32'(an), 32'hE);
    end
    step();                chk("enup_gap",   32'(an), 32'hF);

    // Randomized digits, dots and blanking
    for (int i = 0; i < 8 * FP; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits = rand_digits();
        dots   = 4'($urandom_range(0, 15));
        lzb    = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Reset pulsed during digit 3 showing
    digits = 16'h9021;
    step_to(2 + 3 * DP);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_an",    32'(an),    32'hF);
    chk("midrst_frame", 32'(frame), 32'h0);
    chk("midrst_idx",   32'(idx),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (FP - 1) step();
    chk("first_wrap_pre",  32'(frame), 32'h0);
    step();
    chk("first_wrap",      32'(frame), 32'h1);
    repeat (FP) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the clock's 4-digit common-anode 7-segment display. One shared segment decoder is driven, one digit at a time, with a 4-bit code and a dot-enable, and the controller drives the active-low digit anodes. It inserts blanking gaps between digits to avoid ghosting and snapshots the displayed value once per frame so a mid-frame time update never tears. It sits between the clock/counter logic (which supplies BCD digits and dot flags) and the segment decoder.

## Interface
- NDIG, 4: number of digits scanned (2..8).
- DWELL, 50000: clock cycles a digit's anode is on (≥1).
- BLANK, 500: clock cycles all anodes are off before each digit (≥1).
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EN  in  1  scan enable; low holds the display dark and restarts the scan.
- DIGITS  in  4*NDIG  BCD codes; digit k = DIGITS[4k+3:4k], digit 0 least significant.
- DOTS  in  NDIG  dot request per digit, bit k = digit k.
- LZB  in  1  leading-zero blanking enable.
- DIN_OUT  out  4  code to the segment decoder; 4'hA means blank.
- DOT_EN  out  1  dot enable to the segment decoder.
- AN  out  NDIG  digit anodes, active-low, at most one low.
- FRAME  out  1  one-cycle pulse at each frame start.
- IDX  out  clog2(NDIG)  index of the current digit.

## Operation
- Registers: state {BLANKING, SHOWING}, idx, cnt (wide enough for max(DWELL,BLANK)-1), snap_dig (4*NDIG), snap_dot (NDIG), FRAME flag.
- All outputs derive only from registers; there is no combinational path from inputs to outputs.
- BLANKING: AN all ones. DIN_OUT/DOT_EN already show digit idx so the decoder has settled before the anode turns on. cnt counts 0..BLANK-1, then state becomes SHOWING with cnt=0.
- SHOWING: AN[idx]=0, all other bits 1. cnt counts 0..DWELL-1, then state becomes BLANKING with cnt=0 and idx=idx+1; idx wraps from NDIG-1 to 0.
- Snapshot: snap_dig/snap_dot load from DIGITS/DOTS on any edge where EN=1, state=BLANKING, idx=0 and cnt=0. At no other time do they change.
- DIN_OUT = snap digit idx, or 4'hA if that digit is blanked. DOT_EN = snap_dot[idx], regardless of blanking.
- Leading-zero blanking (LZB=1): digit k (k≥1) is blanked iff snap digits NDIG-1..k are all 4'h0. Digit 0 is never blanked. LZB is sampled live, not snapshotted.
- FRAME is registered high for exactly one cycle when idx wraps NDIG-1→0. It is not asserted after reset or after EN re-enable.
- EN=0 at an edge: state=BLANKING, idx=0, cnt=0, AN all ones on the next cycle, snapshots held. When EN is raised again, the scan restarts with a full BLANK on digit 0 and a fresh snapshot.
- Input codes 4'hA..4'hF pass through unchanged; the decoder blanks them.

## Timing
- Reset values (asynchronous, take effect immediately): state=BLANKING, idx=0, cnt=0, snap_dig=0, snap_dot=0. Outputs: AN all ones, DIN_OUT=4'h0, DOT_EN=0, FRAME=0, IDX=0.
- Digit period is BLANK+DWELL cycles. Frame period is NDIG*(BLANK+DWELL) cycles.
- With EN held high from reset release, the first qualifying edge loads the snapshot. After BLANK edges, AN[0] goes low for DWELL cycles.
- Anode overlap is impossible: every anode change passes through ≥BLANK all-ones cycles.
- Reset asserted mid-frame forces reset values without a clock edge.

## Test plan
Bench parameters: NDIG=4, DWELL=4, BLANK=2, so the frame is 24 cycles.
- Reset, then hold RST low for 3 cycles → AN=4'b1111, DIN_OUT=0, DOT_EN=0, FRAME=0 with no clock edges required.
- DIGITS=16'h1234, DOTS=0, LZB=0, EN=1 → repeating pattern of 1111×2, 1110×4 (DIN_OUT=4), 1111×2, 1101×4 (3), 1111×2, 1011×4 (2), 1111×2, 0111×4 (1). FRAME pulses once every 24 cycles.
- LZB=1, DIGITS=16'h0050, DOTS=4'b0100 → digits 3 and 2 output 4'hA, digit 2 has DOT_EN=1, digit 1 outputs 5, digit 0 outputs 0. With DIGITS=16'h0000, only digit 0 outputs 0 and the rest output 4'hA.
- DIGITS changes 16'h1234→16'h5678 during digit 2's SHOWING → the rest of that frame still shows 2 and 1, and the next frame shows 8,7,6,5.
- EN dropped during digit 1's SHOWING → AN=1111 on the next cycle and IDX=0. When EN is raised, 2 blank cycles follow, then AN=1110 for 4 cycles.
- RST pulsed low mid-SHOWING of digit 3 → AN=1111 immediately. After release, the scan restarts at digit 0 and FRAME stays low until the first wrap.
